pe_tile_param: RTL

//  Parametrised PE tile for the island-style fabric: K-input LUT CLB with optional output flop, connection
//  box feeding the LUT, and a switch block routing TRACKS tracks on four sides. Configured word-serially

---
 rtl/tinyfpga_pkg.sv | 90 +++++++++
 rtl/pe_clb.sv | 41 ++++
 rtl/pe_tile_param.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/tinyfpga_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tinyfpga_pkg
//  Description : Shared definitions for the island-style fabric tiles:
//                switch-block select encodings, side indices, side-rotation
//                helpers and the config-bitstream size derivations used by
//                both the tile RTL and the bitstream-packing bench.
//  Revision    : 1.0 - initial release
// ============================================================================
package tinyfpga_pkg;

    // Side indices, also the order of the switch-block fields in the bitstream.
    localparam int SIDE_N = 0;
    localparam int SIDE_S = 1;
    localparam int SIDE_E = 2;
    localparam int SIDE_W = 3;

    // Per-output-track switch-block source select.
    typedef enum logic [1:0] {
        SB_STRAIGHT = 2'd0,
        SB_LEFT     = 2'd1,
        SB_RIGHT    = 2'd2,
        SB_CLB      = 2'd3
    } sb_sel_e;

    typedef enum logic [0:0] {
        CFG_IDLE = 1'b0,
        CFG_LOAD = 1'b1
    } cfg_state_e;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    function automatic int lut_bits(input int lut_k);
        return 1 << lut_k;
    endfunction

    function automatic int sel_w(input int tracks);
        return clog2(2 * tracks);
    endfunction

    // LUT table | reg_en | CB selects | SB selects (4 sides x tracks x 2 bits)
    function automatic int cfg_w(input int tracks, input int lut_k);
        return lut_bits(lut_k) + 1 + lut_k * sel_w(tracks) + 8 * tracks;
    endfunction

    function automatic int nwords(input int tracks, input int lut_k, input int bus_w);
        return (cfg_w(tracks, lut_k) + bus_w - 1) / bus_w;
    endfunction

    // Source side for an output on side s. Left of N is W, right of N is E;
    // the other sides are the same picture rotated.
    function automatic int sb_opposite(input int s);
        case (s)
            SIDE_N:  return SIDE_S;
            SIDE_S:  return SIDE_N;
            SIDE_E:  return SIDE_W;
            default: return SIDE_E;
        endcase
    endfunction

    function automatic int sb_left(input int s);
        case (s)
            SIDE_N:  return SIDE_W;
            SIDE_S:  return SIDE_E;
            SIDE_E:  return SIDE_N;
            default: return SIDE_S;
        endcase
    endfunction

    function automatic int sb_right(input int s);
        case (s)
            SIDE_N:  return SIDE_E;
            SIDE_S:  return SIDE_W;
            SIDE_E:  return SIDE_S;
            default: return SIDE_N;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/pe_clb.sv
`default_nettype none
// ============================================================================
//  Module      : pe_clb
//  Description : K-input LUT with an optional output flop.
//  Ports       : clk, rst_n (async active-low)
//                lut_table [2**LUT_K] - truth table, indexed by lut_in
//                reg_en               - 1: registered output, 0: combinational
//                lut_in    [LUT_K]    - LUT inputs from the connection box
//                clb_out              - CLB result
//  Revision    : 1.0 - initial release
// ============================================================================
module pe_clb
    import tinyfpga_pkg::*;
#(
    parameter int LUT_K = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [lut_bits(LUT_K)-1:0]   lut_table,
    input  logic                         reg_en,
    input  logic [LUT_K-1:0]             lut_in,
    output logic                         clb_out
);

    logic lut_out;
    logic lut_q;

    assign lut_out = lut_table[lut_in];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lut_q <= 1'b0;
        end else begin
            lut_q <= lut_out;
        end
    end

    assign clb_out = reg_en ? lut_q : lut_out;

endmodule
`default_nettype wire

// File: rtl/pe_tile_param.sv
`default_nettype none
// ============================================================================
//  Module      : pe_tile_param
//  Description : Parametrised PE tile: LUT CLB (pe_clb), connection box and a
//                four-sided switch block, configured word-serially over a
//                shared config bus. Staged words commit atomically into the
//                active configuration on the last word of a sequence.
//  Ports       : clk, rst_n (async active-low)
//                config_en/config_start/config_addr/config_data - config bus
//                config_done       - 1-cycle pulse after a full commit
//                in_n/s/e/w        - incoming tracks, out_n/s/e/w - outgoing
//                clb_out           - CLB result
//                PE_TILE_READBACK_EN adds config_rd_en, config_rd_data,
//                config_rd_valid (word-serial readback of the active config).
//  Revision    : 1.0 - initial release
// ============================================================================
module pe_tile_param
    import tinyfpga_pkg::*;
#(
    parameter int                ADDR_W  = 8,
    parameter logic [ADDR_W-1:0] ADDRESS = {ADDR_W{1'b0}},
    parameter int                BUS_W   = 8,
    parameter int                TRACKS  = 4,
    parameter int                LUT_K   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               config_en,
    input  logic               config_start,
    input  logic [ADDR_W-1:0]  config_addr,
    input  logic [BUS_W-1:0]   config_data,
    output logic               config_done,
`ifdef PE_TILE_READBACK_EN
    input  logic               config_rd_en,
    output logic [BUS_W-1:0]   config_rd_data,
    output logic               config_rd_valid,
`endif
    input  logic [TRACKS-1:0]  in_n,
    input  logic [TRACKS-1:0]  in_s,
    input  logic [TRACKS-1:0]  in_e,
    input  logic [TRACKS-1:0]  in_w,
    output logic [TRACKS-1:0]  out_n,
    output logic [TRACKS-1:0]  out_s,
    output logic [TRACKS-1:0]  out_e,
    output logic [TRACKS-1:0]  out_w,
    output logic               clb_out
);

    localparam int LUT_BITS = lut_bits(LUT_K);
    localparam int SEL_W    = sel_w(TRACKS);
    localparam int REG_BIT  = LUT_BITS;
    localparam int CB_BASE  = LUT_BITS + 1;
    localparam int SB_BASE  = CB_BASE + LUT_K * SEL_W;
    localparam int CFG_W    = cfg_w(TRACKS, LUT_K);
    localparam int NWORDS   = nwords(TRACKS, LUT_K, BUS_W);
    localparam int CNT_W    = (NWORDS > 1) ? clog2(NWORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NWORDS - 1);

    // ------------------------------------------------------------------
    // Config loader
    // ------------------------------------------------------------------
    cfg_state_e         state;
    cfg_state_e         state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [CFG_W-1:0]   staging;
    logic [CFG_W-1:0]   staging_nxt;
    logic [CFG_W-1:0]   active;
    logic [CFG_W-1:0]   active_nxt;
    logic               done_nxt;
    logic               wr_hit;

    assign wr_hit = config_en && (config_addr == ADDRESS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= CFG_IDLE;
            cnt         <= '0;
            staging     <= '0;
            active      <= '0;
            config_done <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            staging     <= staging_nxt;
            active      <= active_nxt;
            config_done <= done_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        staging_nxt = staging;
        active_nxt  = active;
        done_nxt    = 1'b0;
        if (config_start) begin
            state_nxt   = CFG_IDLE;
            cnt_nxt     = '0;
            staging_nxt = '0;
        end else if (wr_hit) begin
            // Staging only holds CFG_W bits, so padding bits of the last
            // word simply have no destination.
            for (int b = 0; b < CFG_W; b++) begin
                if (cnt == CNT_W'(b / BUS_W)) begin
                    staging_nxt[b] = config_data[b % BUS_W];
                end
            end
            if (cnt == LAST_WORD) begin
                // Commit the merged image on the same edge as the last word.
                active_nxt = staging_nxt;
                cnt_nxt    = '0;
                state_nxt  = CFG_IDLE;
                done_nxt   = 1'b1;
            end else begin
                cnt_nxt    = cnt + 1'b1;
                state_nxt  = CFG_LOAD;
            end
        end
    end

    // ------------------------------------------------------------------
    // Connection box: each LUT input picks one of {in_w, in_n}
    // ------------------------------------------------------------------
    logic [2*TRACKS-1:0] cb_src;
    logic [LUT_K-1:0]    lut_in;

    assign cb_src = {in_w, in_n};

    for (genvar i = 0; i < LUT_K; i++) begin : g_cb
        logic [SEL_W-1:0] sel;
        assign sel = active[CB_BASE + i*SEL_W +: SEL_W];
        if ((1 << SEL_W) == 2 * TRACKS) begin : g_full
            assign lut_in[i] = cb_src[sel];
        end else begin : g_guard
            assign lut_in[i] = (sel < SEL_W'(2 * TRACKS)) ? cb_src[sel] : 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // CLB
    // ------------------------------------------------------------------
    pe_clb #(
        .LUT_K     (LUT_K)
    ) u_clb (
        .clk       (clk),
        .rst_n     (rst_n),
        .lut_table (active[LUT_BITS-1:0]),
        .reg_en    (active[REG_BIT]),
        .lut_in    (lut_in),
        .clb_out   (clb_out)
    );

    // ------------------------------------------------------------------
    // Switch block (flattened side-major: N, S, E, W)
    // ------------------------------------------------------------------
    logic [4*TRACKS-1:0] in_flat;
    logic [4*TRACKS-1:0] out_flat;

    assign in_flat = {in_w, in_e, in_s, in_n};

    for (genvar s = 0; s < 4; s++) begin : g_sb_side
        localparam int OPP   = sb_opposite(s);
        localparam int LEFT  = sb_left(s);
        localparam int RIGHT = sb_right(s);
        for (genvar t = 0; t < TRACKS; t++) begin : g_sb_track
            logic [1:0] sel;
            assign sel = active[SB_BASE + (s*TRACKS + t)*2 +: 2];
            assign out_flat[s*TRACKS + t] =
                (sel == SB_CLB)   ? clb_out                     :
                (sel == SB_RIGHT) ? in_flat[RIGHT*TRACKS + t]   :
                (sel == SB_LEFT)  ? in_flat[LEFT*TRACKS + t]    :
                                    in_flat[OPP*TRACKS + t];
        end
    end

    assign out_n = out_flat[SIDE_N*TRACKS +: TRACKS];
    assign out_s = out_flat[SIDE_S*TRACKS +: TRACKS];
    assign out_e = out_flat[SIDE_E*TRACKS +: TRACKS];
    assign out_w = out_flat[SIDE_W*TRACKS +: TRACKS];

`ifdef PE_TILE_READBACK_EN
    // ------------------------------------------------------------------
    // Readback of the active image, one word per matching read
    // ------------------------------------------------------------------
    localparam int RD_W = NWORDS * BUS_W;

    logic [CNT_W-1:0] rd_cnt;
    logic [RD_W-1:0]  active_pad;
    logic             rd_hit;

    assign active_pad = RD_W'(active);
    assign rd_hit     = config_rd_en && (config_addr == ADDRESS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt          <= '0;
            config_rd_data  <= '0;
            config_rd_valid <= 1'b0;
        end else begin
            config_rd_valid <= 1'b0;
            if (config_start) begin
                rd_cnt <= '0;
            end else if (rd_hit) begin
                config_rd_data  <= BUS_W'(active_pad >> (rd_cnt * BUS_W));
                config_rd_valid <= 1'b1;
                rd_cnt          <= (rd_cnt == LAST_WORD) ? '0 : rd_cnt + 1'b1;
            end
        end
    end
`endif

endmodule
`default_nettype wire
